// File: rtl/sequence_detector_moore_pkg.sv
// Shared types and constants for the 1011 Moore sequence detector.
package sequence_detector_moore_pkg;

  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

endpackage

// File: rtl/sequence_detector_moore_detect_counter.sv
// Free-running detection counter; wraps modulo 2^WIDTH.
module detect_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sequence_detector_moore.sv
// Moore FSM detecting serial pattern 1011 with overlap.
// Optional detection counter enabled by defining SEQ_DET_COUNT_EN.
module sequence_detector_moore
  import sequence_detector_moore_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
`ifdef SEQ_DET_COUNT_EN
  output logic [COUNT_W-1:0] detect_count,
`endif
  output logic               detector_out
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Unused encodings fall through to the default and recover to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = sequence_in ? S1    : IDLE;
      S1:      next_state = sequence_in ? S1    : S10;
      S10:     next_state = sequence_in ? S101  : IDLE;
      S101:    next_state = sequence_in ? S1011 : S10;
      S1011:   next_state = sequence_in ? S1    : S10;
      default: next_state = IDLE;
    endcase
  end

  assign detector_out = (state == S1011);

`ifdef SEQ_DET_COUNT_EN
  detect_counter #(
    .WIDTH (COUNT_W)
  ) u_detect_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (next_state == S1011),
    .count  (detect_count)
  );
`endif

endmodule

// File: tb/tb_sequence_detector_moore.sv
// Directed self-checking bench for sequence_detector_moore (COUNT_W=2).
module tb_sequence_detector_moore;

  logic       clock;
  logic       reset;
  logic       sequence_in;
  logic       detector_out;
`ifdef SEQ_DET_COUNT_EN
  logic [1:0] detect_count;
`endif

  int checks_total  = 0;
  int checks_passed = 0;
  int exp_count     = 0;

  sequence_detector_moore #(
    .COUNT_W (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
`ifdef SEQ_DET_COUNT_EN
    .detect_count (detect_count),
`endif
    .detector_out (detector_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic check_count(input string tag);
`ifdef SEQ_DET_COUNT_EN
    logic [1:0] exp_wrapped;
    exp_wrapped = 2'(exp_count % 4);
    check_output({tag, "_count"}, {6'd0, detect_count}, {6'd0, exp_wrapped});
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  // Called at a negedge; drives one bit, checks after the next rising edge, returns at the following negedge.
  task automatic apply_stimulus(input logic bit_in, input logic exp_out, input string tag);
    sequence_in = bit_in;
    @(posedge clock);
    #1;
    if (exp_out) exp_count++;
    check_output(tag, {7'd0, detector_out}, {7'd0, exp_out});
    check_count(tag);
    @(negedge clock);
  endtask

  // Asserts reset between edges, checks the async clear, then releases at a negedge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    exp_count = 0;
    #1;
    check_output({tag, "_rst_async"}, {7'd0, detector_out}, 8'd0);
    check_count({tag, "_rst_async"});
    @(negedge clock);
    sequence_in = 1'b1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    sequence_in = 1'b0;
    @(negedge clock);

    // Reset held for two cycles while the input toggles.
    for (int i = 0; i < 2; i++) begin
      sequence_in = ~sequence_in;
      @(posedge clock);
      #1;
      check_output("rst_hold", {7'd0, detector_out}, 8'd0);
      check_count("rst_hold");
      @(negedge clock);
    end
    reset = 1'b1;

    // Basic 1011, first bit sampled on the release edge.
    apply_stimulus(1'b1, 1'b0, "basic_b1");
    apply_stimulus(1'b0, 1'b0, "basic_b2");
    apply_stimulus(1'b1, 1'b0, "basic_b3");
    apply_stimulus(1'b1, 1'b1, "basic_b4");
    apply_stimulus(1'b0, 1'b0, "basic_b5");

    // Overlapping 1011011: pulses three cycles apart.
    do_reset("ovl");
    apply_stimulus(1'b1, 1'b0, "ovl_b1");
    apply_stimulus(1'b0, 1'b0, "ovl_b2");
    apply_stimulus(1'b1, 1'b0, "ovl_b3");
    apply_stimulus(1'b1, 1'b1, "ovl_b4");
    apply_stimulus(1'b0, 1'b0, "ovl_b5");
    apply_stimulus(1'b1, 1'b0, "ovl_b6");
    apply_stimulus(1'b1, 1'b1, "ovl_b7");

    // 11011 exercises the S1 self-loop.
    do_reset("self");
    apply_stimulus(1'b1, 1'b0, "self_b1");
    apply_stimulus(1'b1, 1'b0, "self_b2");
    apply_stimulus(1'b0, 1'b0, "self_b3");
    apply_stimulus(1'b1, 1'b0, "self_b4");
    apply_stimulus(1'b1, 1'b1, "self_b5");

    // 10011 never matches.
    do_reset("nomatch");
    apply_stimulus(1'b1, 1'b0, "nomatch_b1");
    apply_stimulus(1'b0, 1'b0, "nomatch_b2");
    apply_stimulus(1'b0, 1'b0, "nomatch_b3");
    apply_stimulus(1'b1, 1'b0, "nomatch_b4");
    apply_stimulus(1'b1, 1'b0, "nomatch_b5");

    // Reset after 101 discards the prefix.
    do_reset("midrst");
    apply_stimulus(1'b1, 1'b0, "midrst_b1");
    apply_stimulus(1'b0, 1'b0, "midrst_b2");
    apply_stimulus(1'b1, 1'b0, "midrst_b3");
    do_reset("midrst2");
    apply_stimulus(1'b1, 1'b0, "midrst_after");
    apply_stimulus(1'b0, 1'b0, "midrst_n2");
    apply_stimulus(1'b1, 1'b0, "midrst_n3");
    apply_stimulus(1'b1, 1'b1, "midrst_n4");

    // Async reset drops an active pulse without a clock edge.
    do_reset("async");
    apply_stimulus(1'b1, 1'b0, "async_b1");
    apply_stimulus(1'b0, 1'b0, "async_b2");
    apply_stimulus(1'b1, 1'b0, "async_b3");
    apply_stimulus(1'b1, 1'b1, "async_b4");
    do_reset("async_drop");

    // Five overlapping detections wrap a 2-bit counter to 1.
    for (int k = 0; k < 5; k++) begin
      if (k == 0) apply_stimulus(1'b1, 1'b0, "wrap_lead");
      apply_stimulus(1'b0, 1'b0, "wrap_0");
      apply_stimulus(1'b1, 1'b0, "wrap_1a");
      apply_stimulus(1'b1, 1'b1, "wrap_1b");
    end
    apply_stimulus(1'b0, 1'b0, "wrap_tail");

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
